image_stream_feeder: RTL
========================

IMAGE_STREAM_FEEDER -- requirements
Module: image_stream_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, pixel word width.
REQ-002 SHALL have parameter NUM_PIXELS, default 1024, pixels per channel per frame (32x32).
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, pixel index width; NUM_PIXELS SHALL be at most 2^ADDR_WIDTH.
REQ-004 SHALL have port clk, input, 1 bit; the single clock, all logic on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit; asynchronous, active-low reset.
REQ-006 SHALL have port wr_en, input, 1 bit; frame-buffer write strobe.
REQ-007 SHALL have port wr_ch, input, 2 bits; target channel 0..2, value 3 invalid.
REQ-008 SHALL have port wr_addr, input, ADDR_WIDTH bits; pixel index.
REQ-009 SHALL have port wr_data, input, DATA_WIDTH bits; pixel value.
REQ-010 SHALL have port start, input, 1 bit; request to stream one frame.
REQ-011 SHALL have port cnn_ready, input, 1 bit; the downstream CNN top can accept a frame.
REQ-012 SHALL have port valid_in, output, 1 bit; pixel-valid strobe to the CNN top.
REQ-013 SHALL have ports data_in0, data_in1, data_in2, output, DATA_WIDTH bits each; channel 0/1/2 pixels.
REQ-014 SHALL have port busy, output, 1 bit; high in WAIT_READY and STREAM.
REQ-015 SHALL have port done, output, 1 bit; one-cycle end-of-frame pulse.
REQ-016 SHALL have port wr_err, output, 1 bit; one-cycle pulse for each rejected write.

Function
REQ-017 SHALL hold three NUM_PIXELS x DATA_WIDTH buffers, one per channel, with no reset on contents.
REQ-018 SHALL, when wr_en=1 in IDLE, write wr_data to buffer[wr_ch][wr_addr] at the clock edge, provided wr_ch<=2 and wr_addr<NUM_PIXELS.
REQ-019 SHALL ignore a write and pulse wr_err the next cycle if wr_en=1 with busy=1, wr_ch=3, or wr_addr>=NUM_PIXELS.
REQ-020 SHALL implement states IDLE, WAIT_READY, STREAM and DONE.
REQ-021 SHALL transition IDLE->WAIT_READY on start=1, and SHALL ignore start in every other state.
REQ-022 SHALL, in WAIT_READY at an edge where cnn_ready=1, enter STREAM, set valid_in=1 and load data_in0..2 with pixel 0 of each channel.
REQ-023 SHALL, in STREAM, present pixel k on the k-th valid cycle, one pixel per clock, without gaps, ignoring cnn_ready after entry.
REQ-024 SHALL, at the edge after pixel NUM_PIXELS-1 is presented, drive valid_in=0, drive data_in0..2 to 0, and enter DONE.
REQ-025 SHALL drive done=1 for exactly the one DONE cycle, then return to IDLE.
REQ-026 SHALL keep valid_in high for exactly NUM_PIXELS consecutive cycles per frame.
REQ-027 SHALL hold data_in0..2 at 0 whenever valid_in=0.
REQ-028 SHALL wrap its pixel index counter only on frame restart, never within a frame.
REQ-029 SHALL, when start and an IDLE write occur in the same cycle, perform the write and leave WAIT_READY with the updated buffer contents.

Reset
REQ-030 SHALL, on resetn=0 at any time including mid-frame, force state IDLE, index counter to 0, and valid_in, data_in0..2, busy, done and wr_err to 0.
REQ-031 SHALL NOT accept a frame restart without a new start pulse after resetn deasserts.

Verification
REQ-032 Load ch0[k]=k, ch1[k]=k+1024, ch2[k]=k+2048; pulse start; raise cnn_ready 5 cycles later -> valid_in high for 1024 cycles; data_in0 runs 0..1023 and data_in2 runs 2048..3071; done pulses once; busy drops with done.
REQ-033 Write with wr_ch=3, then with wr_addr=1024 (ADDR_WIDTH=11), then during STREAM -> wr_err pulses once per write; buffer contents are unchanged on a re-stream.
REQ-034 Assert resetn=0 at pixel 500 -> all outputs are 0 immediately; state is IDLE; a subsequent start streams from pixel 0.
REQ-035 Pulse start while cnn_ready is already 1 -> first valid_in appears on the cycle after WAIT_READY; start pulses during STREAM have no effect.
REQ-036 Stream two back-to-back frames: start asserted in the cycle after done -> two separate 1024-cycle bursts with identical data.

Source files
------------

// File: rtl/image_stream_feeder.sv
// Image stream feeder: three per-channel frame buffers loaded through a write
// port, then streamed one pixel per clock to a downstream CNN once it is ready.
module image_stream_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PIXELS = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [1:0]            wr_ch,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  cnn_ready,
  output logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_in0,
  output logic [DATA_WIDTH-1:0] data_in1,
  output logic [DATA_WIDTH-1:0] data_in2,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_err
);

  // Buffer index width; the pixel counter keeps the full ADDR_WIDTH.
  localparam int MW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX  = ADDR_WIDTH'(NUM_PIXELS - 1);
  localparam logic [ADDR_WIDTH:0]   PIX_LIMIT = (ADDR_WIDTH + 1)'(NUM_PIXELS);
  localparam logic [MW-1:0]         FIRST_IDX = '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_READY,
    STREAM,
    DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pix;
  logic [ADDR_WIDTH-1:0]   pix_nxt;
  logic                    write_ok;
  logic [MW-1:0]           waddr;

  logic [DATA_WIDTH-1:0]   mem0 [NUM_PIXELS];
  logic [DATA_WIDTH-1:0]   mem1 [NUM_PIXELS];
  logic [DATA_WIDTH-1:0]   mem2 [NUM_PIXELS];

  // Write acceptance: only while not streaming, valid channel, in-range index.
  always_comb begin
    write_ok = wr_en && !busy && (wr_ch != 2'd3) && ({1'b0, wr_addr} < PIX_LIMIT);
    waddr    = wr_addr[MW-1:0];
    pix_nxt  = pix + ADDR_WIDTH'(1);
  end

  // Frame buffer storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (write_ok) begin
      case (wr_ch)
        2'd0:    mem0[waddr] <= wr_data;
        2'd1:    mem1[waddr] <= wr_data;
        2'd2:    mem2[waddr] <= wr_data;
        default: ;
      endcase
    end
  end

  // One-cycle error pulse for every write strobe that was not accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wr_err <= 1'b0;
    else         wr_err <= wr_en && !write_ok;
  end

  // Frame sequencer with registered stream outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      pix      <= '0;
      valid_in <= 1'b0;
      data_in0 <= '0;
      data_in1 <= '0;
      data_in2 <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= WAIT_READY;
            busy  <= 1'b1;
            pix   <= '0;
          end
        end
        WAIT_READY: begin
          if (cnn_ready) begin
            state    <= STREAM;
            valid_in <= 1'b1;
            pix      <= '0;
            data_in0 <= mem0[FIRST_IDX];
            data_in1 <= mem1[FIRST_IDX];
            data_in2 <= mem2[FIRST_IDX];
          end
        end
        STREAM: begin
          // pix is the pixel currently on the outputs; the next one is fetched ahead.
          if (pix == LAST_PIX) begin
            state    <= DONE;
            valid_in <= 1'b0;
            data_in0 <= '0;
            data_in1 <= '0;
            data_in2 <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            pix      <= pix_nxt;
            data_in0 <= mem0[pix_nxt[MW-1:0]];
            data_in1 <= mem1[pix_nxt[MW-1:0]];
            data_in2 <= mem2[pix_nxt[MW-1:0]];
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
